axi_ar_allocator: RTL and testbench
===================================

AXI_AR_ALLOCATOR -- requirements
Module: axi_ar_allocator

Interface
REQ-001 SHALL have parameter N_TARG_PORT, default 4: number of requesting target ports.
REQ-002 SHALL have parameter PAYLOAD_WIDTH, default 64: width of the packed AR payload (addr, len, size, burst, id, etc.).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8: maximum number of read bursts in flight.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-006 SHALL have port arvalid_i, input, N_TARG_PORT: per-requester AR valid.
REQ-007 SHALL have port ardata_i, input, N_TARG_PORT x PAYLOAD_WIDTH: per-requester payload.
REQ-008 SHALL have port arready_o, output, N_TARG_PORT: per-requester AR ready.
REQ-009 SHALL have port arvalid_o, output, 1: AR valid to the initiator port.
REQ-010 SHALL have port ardata_o, output, PAYLOAD_WIDTH: payload of the granted requester.
REQ-011 SHALL have port arsrc_o, output, clog2(N_TARG_PORT): index of the granted requester, used for R routing.
REQ-012 SHALL have port arready_i, input, 1: AR ready from the initiator port.
REQ-013 SHALL have port rlast_done_i, input, 1: one R burst completed (rvalid & rready & rlast).
REQ-014 SHALL have port full_counter_o, output, 1: outstanding count == MAX_OUTSTANDING.
REQ-015 SHALL have port outstanding_trans_o, output, 1: outstanding count != 0.

Function
REQ-016 SHALL arbitrate round-robin: the candidate is the first asserted arvalid_i at or after rr_ptr, searching upward and wrapping at N_TARG_PORT-1 -> 0.
REQ-017 SHALL grant combinationally in UNLOCKED state (zero-cycle latency): arvalid_o=1, ardata_o/arsrc_o from the candidate, when any arvalid_i=1 and full_counter_o=0.
REQ-018 SHALL drive arready_o[k] = arready_i only for the granted k; all other bits 0.
REQ-019 SHALL use FSM states UNLOCKED and LOCKED.
REQ-020 SHALL go UNLOCKED->LOCKED when arvalid_o=1 and arready_i=0, registering the granted index.
REQ-021 SHALL, in LOCKED, present the registered index regardless of other requests or rr_ptr, keeping the grant stable per AXI.
REQ-022 SHALL go LOCKED->UNLOCKED on the arready_i=1 cycle (handshake).
REQ-023 SHALL, on each handshake (arvalid_o & arready_i), set rr_ptr = granted+1 mod N_TARG_PORT; rr_ptr SHALL be unchanged otherwise.
REQ-024 SHALL suppress new grants when full_counter_o=1: arvalid_o=0 and arready_o=0 in UNLOCKED; a LOCKED grant stays asserted, since a grant is entered only when not full.
REQ-025 SHALL hold an outstanding counter of width clog2(MAX_OUTSTANDING+1): +1 on handshake, -1 on rlast_done_i, unchanged when both occur together.
REQ-026 SHALL saturate the counter: ignore rlast_done_i at 0; never increment past MAX_OUTSTANDING.
REQ-027 SHALL derive full_counter_o and outstanding_trans_o combinationally from the registered counter.
REQ-028 SHALL drive ardata_o and arsrc_o to 0 when arvalid_o=0.

Reset
REQ-029 SHALL, on rst_n=0 at a clk edge, reset: FSM=UNLOCKED, rr_ptr=0, locked index=0, counter=0.
REQ-030 SHALL, during reset, drive arvalid_o=0, arready_o=0, ardata_o=0, arsrc_o=0, full_counter_o=0, outstanding_trans_o=0.
REQ-031 SHALL, on reset mid-LOCKED, abandon the grant; no handshake is counted that cycle.

Structure
REQ-032 SHALL place the FSM state enum and the counter-width/index-width localparam functions in the shared AXI node package.
REQ-033 SHALL implement arbitration in sub-module axi_rr_arbiter_comb (request vector + pointer -> one-hot grant + index); counter and FSM stay in the top.

Verification
REQ-034 SHALL verify with N=4 and arvalid_i=4'b1111 held, arready_i=1 each cycle: grants 0,1,2,3,0 and rr_ptr wraps to 0.
REQ-035 SHALL verify: req0 granted, arready_i=0 for 3 cycles while req1 rises -> arsrc_o stays 0, ardata_o stable; handshake on cycle 4; next grant is 1.
REQ-036 SHALL verify with MAX_OUTSTANDING=2: two handshakes -> full_counter_o=1, arvalid_o=0 with requests pending; one rlast_done_i -> grant resumes next cycle.
REQ-037 SHALL verify: handshake and rlast_done_i in the same cycle at count=1 -> count stays 1; rlast_done_i at count 0 -> stays 0, outstanding_trans_o=0.
REQ-038 SHALL verify: rst_n=0 while LOCKED with count=3 -> next cycle all outputs 0, grant restarts from requester 0.

Source files
------------

// File: rtl/axi_ar_allocator_pkg.sv
// Shared AXI node definitions: AR allocator FSM states and width helpers.
package axi_ar_allocator_pkg;

    // Grant-holding FSM: UNLOCKED grants freely, LOCKED pins the current grant.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } ar_state_e;

    // Counter width able to hold 0..max_out inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    // Index width for n requesters; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rr_arbiter_comb.sv
// Combinational round-robin arbiter: first request at or after the pointer wins.
module axi_rr_arbiter_comb
    import axi_ar_allocator_pkg::*;
#(
    parameter int unsigned  N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            int unsigned k;
            k = (int'(i_ptr) + off) % N;
            if (i_req[k]) begin
                o_valid = 1'b1;
                o_idx   = IW'(k);
            end
        end
        if (o_valid) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_ar_allocator.sv
// AR channel allocator: round-robin grant across target ports, grant locking
// until the initiator accepts, and an outstanding read-burst counter.
module axi_ar_allocator
    import axi_ar_allocator_pkg::*;
#(
    parameter int unsigned  N_TARG_PORT     = 4,
    parameter int unsigned  PAYLOAD_WIDTH   = 64,
    parameter int unsigned  MAX_OUTSTANDING = 8,
    localparam int unsigned IW              = idx_width(N_TARG_PORT),
    localparam int unsigned CW              = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [N_TARG_PORT-1:0]                     arvalid_i,
    input  logic [N_TARG_PORT-1:0][PAYLOAD_WIDTH-1:0]  ardata_i,
    output logic [N_TARG_PORT-1:0]                     arready_o,
    output logic                                       arvalid_o,
    output logic [PAYLOAD_WIDTH-1:0]                   ardata_o,
    output logic [IW-1:0]                              arsrc_o,
    input  logic                                       arready_i,
    input  logic                                       rlast_done_i,
    output logic                                       full_counter_o,
    output logic                                       outstanding_trans_o
);

    ar_state_e        r_state;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_lock_idx;
    logic [CW-1:0]    r_count;

    logic [N_TARG_PORT-1:0] w_arb_gnt;
    logic [IW-1:0]          w_arb_idx;
    logic                   w_arb_valid;
    logic                   w_full;
    logic                   w_grant_valid;
    logic [IW-1:0]          w_grant_idx;
    logic                   w_hs;
    logic                   w_dec;

    axi_rr_arbiter_comb #(
        .N (N_TARG_PORT)
    ) u_arb (
        .i_req   (arvalid_i),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_full = (r_count == CW'(MAX_OUTSTANDING));
    assign w_dec  = rlast_done_i && (r_count != '0);

    // Grant selection: locked index wins; otherwise a fresh grant unless full.
    // Everything is gated by rst_n so outputs are quiet during reset.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        arready_o     = '0;
        if (rst_n) begin
            if (r_state == LOCKED) begin
                w_grant_valid         = 1'b1;
                w_grant_idx           = r_lock_idx;
                arready_o[r_lock_idx] = arready_i;
            end else if (w_arb_valid && !w_full) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_arb_idx;
                arready_o     = w_arb_gnt & {N_TARG_PORT{arready_i}};
            end
        end
    end

    assign w_hs                = w_grant_valid && arready_i;
    assign arvalid_o           = w_grant_valid;
    assign arsrc_o             = w_grant_idx;
    assign ardata_o            = w_grant_valid ? ardata_i[w_grant_idx] : '0;
    assign full_counter_o      = rst_n && w_full;
    assign outstanding_trans_o = rst_n && (r_count != '0);

    // FSM: lock a grant the initiator did not accept, release on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= UNLOCKED;
            r_lock_idx <= '0;
        end else begin
            unique case (r_state)
                UNLOCKED: begin
                    if (w_grant_valid && !arready_i) begin
                        r_state    <= LOCKED;
                        r_lock_idx <= w_grant_idx;
                    end
                end
                LOCKED: begin
                    if (arready_i) begin
                        r_state <= UNLOCKED;
                    end
                end
                default: r_state <= UNLOCKED;
            endcase
        end
    end

    // Round-robin pointer moves just past the requester that handshook.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= (w_grant_idx == IW'(N_TARG_PORT - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // Outstanding burst counter, saturating at both ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            unique case ({w_hs, w_dec})
                2'b10: if (!w_full) r_count <= r_count + 1'b1;
                2'b01: r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ar_allocator.sv
// Scoreboard bench for axi_ar_allocator: two instances (deep and shallow
// outstanding limits) driven identically and checked against a behavioural model.
module tb_axi_ar_allocator;

    localparam int N = 4;
    localparam int W = 64;

    typedef struct {
        logic         v;
        logic [1:0]   src;
        logic [W-1:0] data;
        logic [N-1:0] rdy;
        logic         full;
        logic         outst;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [N-1:0]          arvalid;
    logic [N-1:0][W-1:0]   ardata;
    logic                  arready;
    logic                  rlast;

    logic [N-1:0] a_rdy,   b_rdy;
    logic         a_v,     b_v;
    logic [W-1:0] a_data,  b_data;
    logic [1:0]   a_src,   b_src;
    logic         a_full,  b_full;
    logic         a_outst, b_outst;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state per instance.
    int mx[2] = '{8, 2};
    int rr[2];
    bit lk[2];
    int li[2];
    int cnt[2];

    axi_ar_allocator #(
        .N_TARG_PORT     (N),
        .PAYLOAD_WIDTH   (W),
        .MAX_OUTSTANDING (8)
    ) dut_a (
        .clk                 (clk),
        .rst_n               (rst_n),
        .arvalid_i           (arvalid),
        .ardata_i            (ardata),
        .arready_o           (a_rdy),
        .arvalid_o           (a_v),
        .ardata_o            (a_data),
        .arsrc_o             (a_src),
        .arready_i           (arready),
        .rlast_done_i        (rlast),
        .full_counter_o      (a_full),
        .outstanding_trans_o (a_outst)
    );

    axi_ar_allocator #(
        .N_TARG_PORT     (N),
        .PAYLOAD_WIDTH   (W),
        .MAX_OUTSTANDING (2)
    ) dut_b (
        .clk                 (clk),
        .rst_n               (rst_n),
        .arvalid_i           (arvalid),
        .ardata_i            (ardata),
        .arready_o           (b_rdy),
        .arvalid_o           (b_v),
        .ardata_o            (b_data),
        .arsrc_o             (b_src),
        .arready_i           (arready),
        .rlast_done_i        (rlast),
        .full_counter_o      (b_full),
        .outstanding_trans_o (b_outst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predict this cycle's outputs from current inputs, then advance the model.
    task automatic model_step(input int m, output exp_t e);
        bit v;
        bit hs;
        int src;
        int c;
        e = '{v: 1'b0, src: 2'd0, data: '0, rdy: '0, full: 1'b0, outst: 1'b0};
        if (!rst_n) begin
            rr[m] = 0; lk[m] = 0; li[m] = 0; cnt[m] = 0;
            return;
        end
        e.full  = (cnt[m] == mx[m]);
        e.outst = (cnt[m] != 0);
        v = 0; src = 0;
        if (lk[m]) begin
            v = 1; src = li[m];
        end else if (cnt[m] != mx[m]) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (rr[m] + i) % N;
                if (!v && arvalid[k]) begin
                    v = 1; src = k;
                end
            end
        end
        e.v = v;
        if (v) begin
            e.src  = 2'(src);
            e.data = ardata[src];
            if (arready) e.rdy = 4'(1 << src);
        end
        hs = v && arready;
        if (hs) begin
            rr[m] = (src + 1) % N;
            lk[m] = 0;
        end else if (v) begin
            lk[m] = 1;
            li[m] = src;
        end
        c = cnt[m] + (hs ? 1 : 0) - ((rlast && cnt[m] > 0) ? 1 : 0);
        if (c > mx[m]) c = mx[m];
        cnt[m] = c;
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] q, input logic a,
                         input logic l, input logic newdata);
        exp_t e;
        rst_n   = r;
        arvalid = q;
        arready = a;
        rlast   = l;
        if (newdata) begin
            for (int i = 0; i < N; i++) ardata[i] = {$urandom, $urandom};
        end
        model_step(0, e); q_a.push_back(e);
        model_step(1, e); q_b.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: pop the prediction for this cycle and compare both instances.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            cmp("a.arvalid", W'(a_v), W'(e.v));
            cmp("a.arsrc", W'(a_src), W'(e.src));
            cmp("a.ardata", a_data, e.data);
            cmp("a.arready", W'(a_rdy), W'(e.rdy));
            cmp("a.full", W'(a_full), W'(e.full));
            cmp("a.outst", W'(a_outst), W'(e.outst));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            cmp("b.arvalid", W'(b_v), W'(e.v));
            cmp("b.arsrc", W'(b_src), W'(e.src));
            cmp("b.ardata", b_data, e.data);
            cmp("b.arready", W'(b_rdy), W'(e.rdy));
            cmp("b.full", W'(b_full), W'(e.full));
            cmp("b.outst", W'(b_outst), W'(e.outst));
        end
    end

    initial begin
        rst_n   = 1'b0;
        arvalid = '0;
        arready = 1'b0;
        rlast   = 1'b0;
        for (int i = 0; i < N; i++) ardata[i] = {$urandom, $urandom};
        @(posedge clk);
        #1;

        // Reset, then all requesters held with the initiator always ready.
        repeat (2) cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (5) cycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);

        // Requester 0 stalled three cycles while requester 1 rises.
        repeat (2) cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);

        // Fill the shallow instance, stall, then free one slot.
        repeat (4) cycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
        repeat (2) cycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);

        // Simultaneous handshake and completion; completion at zero count.
        repeat (2) cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 4'b0001, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Reset while locked with three outstanding, then restart at requester 0.
        repeat (2) cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 800; t++) begin
            cycle(($urandom_range(0, 59) != 0), 4'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
